// File: rtl/pe_feeder_if.sv
// Host write/start, PE stream and result signals of one pe_feeder.
// slave is the feeder's view; master is the host/PE side.
interface pe_feeder_if #(
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic              wr_sel;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              ovf;
  logic [DATA_W-1:0] pe_in;
  logic [DATA_W-1:0] pe_filter;
  logic              pe_vld;
  logic              pe_clr;
  logic [DATA_W-1:0] pe_out;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, pe_out,
    output busy, ovf, pe_in, pe_filter, pe_vld, pe_clr, res_data, res_valid
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, pe_out,
    input  busy, ovf, pe_in, pe_filter, pe_vld, pe_clr, res_data, res_valid
  );
endinterface

// File: rtl/pe_feeder.sv
// Double-buffered 3x3 window/filter sequencer: streams TAPS act/weight pairs
// to one PE, then captures the PE's result PE_LAT cycles after the last pair.
module pe_feeder #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 9,
  parameter int PE_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  pe_feeder_if.slave   bus
);
  localparam int TAP_W = $clog2(TAPS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_e;
  typedef logic [TAPS-1:0][DATA_W-1:0] buf_t;

  state_e            state_q;
  logic [TAP_W-1:0]  tap_q;
  logic [2:0]        wcnt_q;
  logic              pend_q, ovf_q, busy_q;
  buf_t              act_stg_q, wgt_stg_q, act_act_q, wgt_act_q;
  logic [DATA_W-1:0] pe_in_q, pe_filter_q, res_data_q;
  logic              pe_vld_q, pe_clr_q, res_valid_q;

  logic wr_ok, last_tap, wait_done, launch;

  always_comb begin
    wr_ok     = bus.wr_en && (32'(bus.wr_addr) < TAPS);
    last_tap  = (state_q == STREAM) && (tap_q == TAP_W'(TAPS));
    wait_done = (state_q == WAIT) && (wcnt_q == '0);
    // A request queued on the very exit cycle is still served from IDLE.
    launch    = ((state_q == IDLE) && (bus.start || pend_q)) ||
                (wait_done && pend_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      wcnt_q      <= '0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      act_stg_q   <= '0;
      wgt_stg_q   <= '0;
      act_act_q   <= '0;
      wgt_act_q   <= '0;
      pe_in_q     <= '0;
      pe_filter_q <= '0;
      pe_vld_q    <= 1'b0;
      pe_clr_q    <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      pe_in_q     <= '0;
      pe_filter_q <= '0;
      pe_vld_q    <= 1'b0;
      pe_clr_q    <= 1'b0;
      res_valid_q <= 1'b0;

      if (wr_ok) begin
        if (bus.wr_sel) wgt_stg_q[bus.wr_addr] <= bus.wr_data;
        else            act_stg_q[bus.wr_addr] <= bus.wr_data;
      end

      if (bus.start && (state_q != IDLE)) begin
        if (pend_q) ovf_q  <= 1'b1;
        else        pend_q <= 1'b1;
      end

      case (state_q)
        STREAM: begin
          if (last_tap) begin
            state_q <= WAIT;
            wcnt_q  <= 3'(PE_LAT - 1);
          end else begin
            pe_vld_q    <= 1'b1;
            pe_clr_q    <= (tap_q == '0);
            pe_in_q     <= act_act_q[tap_q];
            pe_filter_q <= wgt_act_q[tap_q];
            tap_q       <= tap_q + 1'b1;
          end
        end
        WAIT: begin
          if (wait_done) begin
            res_data_q  <= bus.pe_out;
            res_valid_q <= 1'b1;
            if (!pend_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        default: ;
      endcase

      // Tap 0 is issued straight from staging so it lands in the first cycle.
      if (launch) begin
        act_act_q   <= act_stg_q;
        wgt_act_q   <= wgt_stg_q;
        pe_in_q     <= act_stg_q[0];
        pe_filter_q <= wgt_stg_q[0];
        pe_vld_q    <= 1'b1;
        pe_clr_q    <= 1'b1;
        tap_q       <= TAP_W'(1);
        pend_q      <= 1'b0;
        state_q     <= STREAM;
        busy_q      <= 1'b1;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;
  assign bus.pe_in     = pe_in_q;
  assign bus.pe_filter = pe_filter_q;
  assign bus.pe_vld    = pe_vld_q;
  assign bus.pe_clr    = pe_clr_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: behavioural PE, dot-product reference model over a
// mirror of the staging buffers, table vectors, directed and random sequences.
module tb_pe_feeder;
  localparam int DW     = 8;
  localparam int TAPS   = 9;
  localparam int PE_LAT = 1;
  localparam int LAT    = TAPS + PE_LAT + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_feeder_if #(.DATA_W(DW)) bus ();
  pe_feeder #(.DATA_W(DW), .TAPS(TAPS), .PE_LAT(PE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural PE, one cycle of latency.
  int acc;
  always @(posedge clk) begin
    if (rst) begin
      acc = 0;
      bus.pe_out <= '0;
    end else if (bus.pe_vld) begin
      acc = (bus.pe_clr ? 0 : acc) + int'(bus.pe_in) * int'(bus.pe_filter);
      bus.pe_out <= acc[7:0];
    end
  end

  int checks = 0;
  int errors = 0;
  int m_act[TAPS];
  int m_wgt[TAPS];

  typedef struct { int a; int w; int exp; } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int dot();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += m_act[k] * m_wgt[k];
    return s % 256;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0;
    for (int k = 0; k < TAPS; k++) begin m_act[k] = 0; m_wgt[k] = 0; end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input int sel, input int addr, input int data);
    bus.wr_en = 1'b1; bus.wr_sel = 1'(sel);
    bus.wr_addr = 4'(addr); bus.wr_data = 8'(data);
    if (addr < TAPS) begin
      if (sel != 0) m_wgt[addr] = data; else m_act[addr] = data;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic fill(input int a, input int w);
    for (int k = 0; k < TAPS; k++) begin wr(0, k, a); wr(1, k, w); end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered in the first cycle after the start edge; lat counts from there.
  task automatic wait_res(input int bound, output int d, output int lat);
    d = -1; lat = -1;
    for (int c = 1; c <= bound; c++) begin
      if (bus.res_valid) begin d = int'(bus.res_data); lat = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic count_rv(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      if (bus.res_valid) cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, lat, cnt, e1, e2;
    bit vl[1:40];
    bit rv[1:40];
    int rd[1:40];
    int rq[$];

    vecs[0] = '{10, 10, 132};
    vecs[1] = '{5, 5, 225};
    vecs[2] = '{2, 2, 36};
    vecs[3] = '{20, 20, 16};
    vecs[4] = '{0, 0, 0};
    vecs[5] = '{255, 255, 9};
    vecs[6] = '{3, 7, 189};

    do_reset();
    chk("rst busy", int'(bus.busy), 0);
    chk("rst ovf", int'(bus.ovf), 0);
    chk("rst pe_vld", int'(bus.pe_vld), 0);
    chk("rst pe_clr", int'(bus.pe_clr), 0);
    chk("rst pe_in", int'(bus.pe_in), 0);
    chk("rst pe_filter", int'(bus.pe_filter), 0);
    chk("rst res_valid", int'(bus.res_valid), 0);
    chk("rst res_data", int'(bus.res_data), 0);

    // Single window, cycle-accurate.
    fill(10, 10);
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("c1 vld@%0d", k), int'(bus.pe_vld), (k <= TAPS) ? 1 : 0);
      chk($sformatf("c1 clr@%0d", k), int'(bus.pe_clr), (k == 1) ? 1 : 0);
      chk($sformatf("c1 rv@%0d", k), int'(bus.res_valid), (k == LAT) ? 1 : 0);
      chk($sformatf("c1 busy@%0d", k), int'(bus.busy), (k <= TAPS + PE_LAT) ? 1 : 0);
      if (k <= TAPS) begin
        chk($sformatf("c1 pe_in@%0d", k), int'(bus.pe_in), 10);
        chk($sformatf("c1 pe_filter@%0d", k), int'(bus.pe_filter), 10);
      end
      if (k == LAT) chk("c1 res_data", int'(bus.res_data), 132);
      @(negedge clk);
    end

    // Table of uniform windows.
    for (int i = 0; i < 7; i++) begin
      fill(vecs[i].a, vecs[i].w);
      pulse_start();
      wait_res(30, d, lat);
      chk($sformatf("vec%0d res", i), d, vecs[i].exp);
      chk($sformatf("vec%0d lat", i), lat, LAT);
      chk($sformatf("vec%0d busy", i), int'(bus.busy), 0);
      @(negedge clk);
    end

    // Back-to-back via pend: 5x5, then act->2, then act->20.
    fill(5, 5);
    pulse_start();
    fork
      begin
        for (int k = 0; k < TAPS; k++) begin bus.start = (k == 2); wr(0, k, 2); end
        bus.start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < TAPS; k++) begin bus.start = (k == 2); wr(0, k, 20); end
        bus.start = 1'b0;
      end
      begin
        for (int c = 1; c <= 40; c++) begin
          vl[c] = bus.pe_vld; rv[c] = bus.res_valid; rd[c] = int'(bus.res_data);
          @(negedge clk);
        end
      end
    join
    cnt = 0;
    rq.delete();
    for (int c = 1; c <= 40; c++) begin
      if (vl[c]) cnt++;
      if (rv[c]) rq.push_back(rd[c]);
    end
    chk("b2b pairs", cnt, 3 * TAPS);
    chk("b2b gap", int'(vl[TAPS + 1]), 0);
    chk("b2b tap0 w/ rv", int'(vl[LAT]) + int'(rv[LAT]), 2);
    chk("b2b 3rd start", int'(vl[2 * (TAPS + PE_LAT) + 1]), 1);
    chk("b2b nres", rq.size(), 3);
    if (rq.size() == 3) begin
      chk("b2b res0", rq[0], 225);
      chk("b2b res1", rq[1], 90);
      chk("b2b res2", rq[2], 132);
    end
    chk("b2b ovf", int'(bus.ovf), 0);

    // Overflow: one start queued, two dropped.
    pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    count_rv(40, cnt);
    chk("ovf nres", cnt, 2);
    chk("ovf flag", int'(bus.ovf), 1);
    do_reset();
    chk("ovf cleared", int'(bus.ovf), 0);

    // Launch-cycle write excluded; overwrites during stream go to next window.
    for (int k = 0; k < TAPS; k++) begin wr(0, k, k + 1); wr(1, k, 1); end
    e1 = dot();
    bus.start = 1'b1;
    wr(0, 0, 100);
    bus.start = 1'b0;
    fork
      for (int k = 1; k < TAPS; k++) wr(0, k, 2);
      wait_res(30, d, lat);
    join
    chk("ovw res", d, 45);
    chk("ovw model", d, e1);
    @(negedge clk);
    e2 = dot();
    pulse_start();
    wait_res(30, d, lat);
    chk("ovw next", d, 116);
    chk("ovw next model", d, e2);
    @(negedge clk);

    // Reset mid-stream at tap 4.
    fill(3, 3);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("mid tap4 vld", int'(bus.pe_vld), 1);
    rst = 1'b1;
    for (int k = 0; k < TAPS; k++) begin m_act[k] = 0; m_wgt[k] = 0; end
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst vld", int'(bus.pe_vld), 0);
    chk("mid rst busy", int'(bus.busy), 0);
    count_rv(20, cnt);
    chk("mid no rv", cnt, 0);
    pulse_start();
    wait_res(30, d, lat);
    chk("mid zero res", d, 0);
    chk("mid zero lat", lat, LAT);
    @(negedge clk);

    // Out-of-range addresses are ignored.
    fill(7, 3);
    pulse_start();
    wait_res(30, d, lat);
    chk("oor base", d, 189);
    @(negedge clk);
    for (int a = TAPS; a < 16; a++) begin wr(0, a, 255); wr(1, a, 255); end
    pulse_start();
    wait_res(30, d, lat);
    chk("oor after", d, 189);
    @(negedge clk);

    // Random windows against the dot-product model.
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < TAPS; k++) begin
        wr(0, k, int'($urandom_range(0, 255)));
        wr(1, k, int'($urandom_range(0, 255)));
      end
      wr(int'($urandom_range(0, 1)), int'($urandom_range(TAPS, 15)), int'($urandom_range(0, 255)));
      e1 = dot();
      pulse_start();
      fork
        for (int j = 0; j < 8; j++)
          wr(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        wait_res(30, d, lat);
      join
      chk($sformatf("rnd%0d res", it), d, e1);
      chk($sformatf("rnd%0d lat", it), lat, LAT);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_feeder.md
# pe_feeder

Sequencer that drives one `pe` processing element. It holds a 3x3 activation window and a 3x3 filter in double-buffered registers and streams the nine activation/weight pairs to the PE, one pair per clock. After the stream it captures the PE's 8-bit accumulated result. It sits between the host/buffer-write side and the `pe` array. Staging writes for the next window can proceed while the current window streams.

## Interface

Parameters:
- DATA_W, 8: width of activations, weights, and the PE result.
- TAPS, 9: pairs per window; addresses are 0..TAPS-1.
- PE_LAT, 1: cycles from the last streamed pair to a valid `pe_out`; legal range 1..7.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  staging write strobe.
- wr_sel  in  1  target buffer: 0 = activation, 1 = weight.
- wr_addr  in  4  tap index.
- wr_data  in  DATA_W  write data.
- start  in  1  request to stream one window.
- busy  out  1  high in any state other than IDLE.
- ovf  out  1  sticky flag: a start was dropped.
- pe_in  out  DATA_W  activation to the PE.
- pe_filter  out  DATA_W  weight to the PE.
- pe_vld  out  1  the current pair is valid.
- pe_clr  out  1  high with tap 0; the PE restarts its accumulation.
- pe_out  in  DATA_W  result from the PE.
- res_data  out  DATA_W  captured result.
- res_valid  out  1  one-cycle pulse when `res_data` updates.

## Operation

Buffers:
- Staging buffers: act_stg[TAPS] and wgt_stg[TAPS]. Active buffers: act_act[TAPS] and wgt_act[TAPS].
- A write with wr_en=1 and wr_addr<TAPS updates the selected staging entry. A write with wr_addr>=TAPS is ignored and has no side effects.
- Copy staging to active happens at stream launch and uses pre-edge staging contents. A write in the launch cycle is not part of that window; it stays in staging for the next window.
- Active buffers are never written during a stream.

FSM states:
- IDLE: on start, copy staging to active, go to STREAM with tap=0.
- STREAM: drive the tap's pair with pe_vld=1 and pe_clr=(tap==0), then increment tap. After tap TAPS-1, go to WAIT with wcnt=PE_LAT-1.
- WAIT: decrement wcnt. When wcnt==0, capture pe_out into res_data and pulse res_valid. Then:
  - if pend=1, copy staging to active, clear pend, and go to STREAM with tap=0;
  - otherwise go to IDLE.

Start handling:
- A start while busy sets pend (one-deep queue).
- A start while busy with pend already 1 is dropped and sets ovf. ovf is cleared only by rst.
- A start in the same cycle as the WAIT exit is treated as busy: it sets pend, or sets ovf if pend is already 1.

Outputs outside STREAM: pe_in=0, pe_filter=0, pe_vld=0, pe_clr=0.

Reset (rst=1, any state, including mid-stream):
- Next state is IDLE, tap=0, pend=0, ovf=0.
- All four buffers clear to 0.
- res_data=0, res_valid=0, busy=0, and all pe_* outputs are 0.
- A result in flight is discarded; no res_valid pulse is issued for it.

## Timing

- All outputs are registered.
- Start sampled at edge T (IDLE): pe_vld is high in cycles T+1..T+TAPS, tap k in cycle T+1+k, pe_clr in cycle T+1 only.
- busy rises in cycle T+1 and falls in the cycle after the WAIT exit when pend=0.
- pe_out is sampled at the edge ending cycle T+TAPS+PE_LAT. res_valid is high in cycle T+TAPS+PE_LAT+1. res_data holds that value until the next capture.
- Back-to-back windows (pend set): tap 0 of the next window appears in the same cycle as res_valid. The dead gap between windows is PE_LAT cycles.
- Throughput: one window per TAPS+PE_LAT cycles.

## Test plan

The bench uses a behavioural PE with PE_LAT=1: on pe_vld, acc = (pe_clr ? 0 : acc) + a*b, and pe_out <= acc[7:0].

- All taps 10/10, start once -> 9 pairs of (10,10), pe_clr on the first only, res_data=132 (900 mod 256), res_valid one cycle at start+11, busy low afterward.
- Four windows with all taps 5/5, 2/2, 20/20, 10/10. Each window is written during the previous stream, and start is pulsed once per window while busy -> results 225, 36, 16, 132 in order. 1-cycle gap between streams, ovf=0.
- Two extra starts while busy with pend=1 -> ovf=1 and exactly two results total. rst clears ovf.
- Taps 0..8 with activation=k+1 and weight=1; overwrite staging during the stream -> res_data=45 (streamed values unaffected); next window reflects the new staging. Same-cycle write at launch is not included in that window.
- rst asserted at tap 4 -> next cycle pe_vld=0, busy=0, res_valid never pulses. A following start with unwritten buffers gives res_data=0.
- Write with wr_addr=9..15 -> no staging change; the following result is unchanged from the prior window.
